// File: rtl/data_array_burst_if.sv
// Bundled CPU, fill and evict signals of the burst data array.
interface data_array_burst_if #(
   parameter int ASSOC      = 8,
   parameter int DATA_SIZE  = 32,
   parameter int BLOCK_SIZE = 6,
   parameter int INDEX_SIZE = 7,
   parameter int BEAT_WORDS = 4
);
   logic [INDEX_SIZE-1:0]           index;
   logic [$clog2(ASSOC)-1:0]        way;
   logic [BLOCK_SIZE-1:0]           word;
   logic [2:0]                      op;
   logic [DATA_SIZE-1:0]            wr_data;
   logic [DATA_SIZE/8-1:0]          wr_be;
   logic [DATA_SIZE-1:0]            rd_data;
   logic                            rd_valid;
   logic [BEAT_WORDS*DATA_SIZE-1:0] fill_data;
   logic                            fill_valid;
   logic                            fill_ready;
   logic [BEAT_WORDS*DATA_SIZE-1:0] evict_data;
   logic                            evict_valid;
   logic                            evict_ready;
   logic                            busy;
   logic                            done;

   modport master (
      output index, way, word, op, wr_data, wr_be, fill_data, fill_valid, evict_ready,
      input  rd_data, rd_valid, fill_ready, evict_data, evict_valid, busy, done
   );

   modport slave (
      input  index, way, word, op, wr_data, wr_be, fill_data, fill_valid, evict_ready,
      output rd_data, rd_valid, fill_ready, evict_data, evict_valid, busy, done
   );
endinterface

// File: rtl/data_array_burst.sv
// Set-associative cache data array: byte-enabled CPU word access plus
// whole-line fill and evict moved as multi-word beats over valid/ready handshakes.
module data_array_burst #(
   parameter int ASSOC      = 8,
   parameter int DATA_SIZE  = 32,
   parameter int BLOCK_SIZE = 6,
   parameter int INDEX_SIZE = 7,
   parameter int BEAT_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   data_array_burst_if.slave bus
);
   localparam int WAY_W  = $clog2(ASSOC);
   localparam int WORDS  = 1 << BLOCK_SIZE;
   localparam int BEATS  = WORDS / BEAT_WORDS;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LINE_W = INDEX_SIZE + WAY_W;
   localparam int ADDR_W = LINE_W + BLOCK_SIZE;
   localparam int BYTES  = DATA_SIZE / 8;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   localparam logic [2:0] OP_WRITE = 3'b001;
   localparam logic [2:0] OP_READ  = 3'b010;
   localparam logic [2:0] OP_FILL  = 3'b011;
   localparam logic [2:0] OP_EVICT = 3'b101;

   typedef enum logic [1:0] { IDLE, FILL, EVICT } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [LINE_W-1:0]    line_q, line_d;
   logic                 done_q, done_d;
   logic                 beat_fire;
   logic [ADDR_W-1:0]    cpu_addr;
   logic [DATA_SIZE-1:0] mem [0:(1<<ADDR_W)-1];

   // Word i of the beat selected by cnt lives at offset cnt*BEAT_WORDS+i of the line.
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [LINE_W-1:0] line,
                                                    input logic [CNT_W-1:0]  cnt,
                                                    input int                i);
      return {line, BLOCK_SIZE'(int'(cnt) * BEAT_WORDS + i)};
   endfunction

   assign cpu_addr  = {bus.index, bus.way, bus.word};
   assign beat_fire = ((state_q == FILL) && bus.fill_valid) ||
                      ((state_q == EVICT) && bus.evict_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.op == OP_FILL) begin
               state_d = FILL;
               cnt_d   = '0;
               line_d  = {bus.index, bus.way};
            end else if (bus.op == OP_EVICT) begin
               state_d = EVICT;
               cnt_d   = '0;
               line_d  = {bus.index, bus.way};
            end
         end
         FILL, EVICT: begin
            if (beat_fire) begin
               if (cnt_q == LAST_BEAT) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // CPU reads are only honoured in IDLE; rd_data keeps its last value otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else if ((state_q == IDLE) && (bus.op == OP_READ)) begin
         bus.rd_data  <= mem[cpu_addr];
         bus.rd_valid <= 1'b1;
      end else begin
         bus.rd_valid <= 1'b0;
      end
   end

   // The array is never reset; EVICT performs no writes so evicted beats stay coherent.
   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && (bus.op == OP_WRITE)) begin
         for (int b = 0; b < BYTES; b++) begin
            if (bus.wr_be[b]) begin
               mem[cpu_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
            end
         end
      end
      if ((state_q == FILL) && bus.fill_valid) begin
         for (int i = 0; i < BEAT_WORDS; i++) begin
            mem[beat_addr(line_q, cnt_q, i)] <= bus.fill_data[i*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   always_comb begin
      bus.evict_data = '0;
      for (int i = 0; i < BEAT_WORDS; i++) begin
         bus.evict_data[i*DATA_SIZE +: DATA_SIZE] = mem[beat_addr(line_q, cnt_q, i)];
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.fill_ready  = (state_q == FILL);
   assign bus.evict_valid = (state_q == EVICT);
   assign bus.done        = done_q;
endmodule

// File: tb/tb_data_array_burst.sv
// Randomized self-checking bench for data_array_burst against a word-addressed
// reference model of the array contents.
module tb_data_array_burst;
   localparam int ASSOC      = 8;
   localparam int DATA_SIZE  = 32;
   localparam int BLOCK_SIZE = 6;
   localparam int INDEX_SIZE = 7;
   localparam int BEAT_WORDS = 4;
   localparam int WAY_W      = $clog2(ASSOC);
   localparam int BE_W       = DATA_SIZE / 8;
   localparam int WORDS      = 1 << BLOCK_SIZE;
   localparam int BEATS      = WORDS / BEAT_WORDS;
   localparam int BEAT_BITS  = BEAT_WORDS * DATA_SIZE;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_WRITE = 3'b001;
   localparam logic [2:0] OP_READ  = 3'b010;
   localparam logic [2:0] OP_FILL  = 3'b011;
   localparam logic [2:0] OP_EVICT = 3'b101;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [DATA_SIZE-1:0] model [int];
   logic [BEAT_BITS-1:0] beat_q [BEATS];

   data_array_burst_if #(
      .ASSOC(ASSOC), .DATA_SIZE(DATA_SIZE), .BLOCK_SIZE(BLOCK_SIZE),
      .INDEX_SIZE(INDEX_SIZE), .BEAT_WORDS(BEAT_WORDS)
   ) bus ();

   data_array_burst #(
      .ASSOC(ASSOC), .DATA_SIZE(DATA_SIZE), .BLOCK_SIZE(BLOCK_SIZE),
      .INDEX_SIZE(INDEX_SIZE), .BEAT_WORDS(BEAT_WORDS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int key(input int idx, input int w, input int wd);
      return (idx * ASSOC + w) * WORDS + wd;
   endfunction

   function automatic logic [DATA_SIZE-1:0] merge(input logic [DATA_SIZE-1:0] old_w,
                                                  input logic [DATA_SIZE-1:0] new_w,
                                                  input logic [BE_W-1:0]      be);
      logic [DATA_SIZE-1:0] r;
      r = old_w;
      for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [BEAT_BITS-1:0] rand_beat();
      logic [BEAT_BITS-1:0] b;
      for (int i = 0; i < BEAT_WORDS; i++) b[i*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'($urandom);
      return b;
   endfunction

   function automatic logic [BEAT_BITS-1:0] model_beat(input int idx, input int w, input int k);
      logic [BEAT_BITS-1:0] b;
      for (int i = 0; i < BEAT_WORDS; i++)
         b[i*DATA_SIZE +: DATA_SIZE] = model[key(idx, w, k*BEAT_WORDS + i)];
      return b;
   endfunction

   function automatic void model_fill_beat(input int idx, input int w, input int k,
                                           input logic [BEAT_BITS-1:0] data);
      for (int i = 0; i < BEAT_WORDS; i++)
         model[key(idx, w, k*BEAT_WORDS + i)] = data[i*DATA_SIZE +: DATA_SIZE];
   endfunction

   task automatic set_addr(input int idx, input int w, input int wd);
      bus.index = INDEX_SIZE'(idx);
      bus.way   = WAY_W'(w);
      bus.word  = BLOCK_SIZE'(wd);
   endtask

   task automatic cpu_write(input int idx, input int w, input int wd,
                            input logic [DATA_SIZE-1:0] data, input logic [BE_W-1:0] be);
      logic [DATA_SIZE-1:0] old_w;
      old_w = model.exists(key(idx, w, wd)) ? model[key(idx, w, wd)] : 'x;
      bus.op = OP_WRITE;
      set_addr(idx, w, wd);
      bus.wr_data = data;
      bus.wr_be   = be;
      tick();
      bus.op = OP_NOP;
      model[key(idx, w, wd)] = merge(old_w, data, be);
   endtask

   task automatic cpu_read(input int idx, input int w, input int wd,
                           output logic v, output logic [DATA_SIZE-1:0] d);
      bus.op = OP_READ;
      set_addr(idx, w, wd);
      tick();
      bus.op = OP_NOP;
      v = bus.rd_valid;
      d = bus.rd_data;
   endtask

   // Drives a full fill of beat_q[] into a line, idling fill_valid before beats sa/sb.
   task automatic run_fill(input int idx, input int w, input int sa, input int sb,
                           output int ready_low, output int busy_low, output int early_done);
      ready_low = 0; busy_low = 0; early_done = 0;
      bus.op = OP_FILL;
      set_addr(idx, w, 0);
      tick();
      bus.op = OP_NOP;
      for (int k = 0; k < BEATS; k++) begin
         if (k == sa || k == sb) begin
            bus.fill_valid = 1'b0;
            bus.fill_data  = rand_beat();
            tick();
         end
         if (bus.fill_ready !== 1'b1) ready_low++;
         if (bus.busy !== 1'b1) busy_low++;
         if (bus.done === 1'b1) early_done++;
         bus.fill_valid = 1'b1;
         bus.fill_data  = beat_q[k];
         tick();
         model_fill_beat(idx, w, k, beat_q[k]);
      end
      bus.fill_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      total++; if (bus.busy !== 1'b0)        begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.fill_ready !== 1'b0)  begin bad++; $display("[TB] FAIL reset_fill_ready: got %b want 0", bus.fill_ready); end
      total++; if (bus.evict_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_evict_valid: got %b want 0", bus.evict_valid); end
      total++; if (bus.done !== 1'b0)        begin bad++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
      total++; if (bus.rd_valid !== 1'b0)    begin bad++; $display("[TB] FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
      total++; if (bus.rd_data !== '0)       begin bad++; $display("[TB] FAIL reset_rd_data: got %h want 0", bus.rd_data); end
      rst_n = 1'b1;
      tick();
      total++; if (bus.busy !== 1'b0)        begin bad++; $display("[TB] FAIL reset_release_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_byte_write();
      logic v;
      logic [DATA_SIZE-1:0] d;
      cpu_write(5, 3, 10, 32'hDEADBEEF, 4'b1111);
      cpu_write(5, 3, 10, 32'h000000AA, 4'b0001);
      cpu_read(5, 3, 10, v, d);
      total++; if (v !== 1'b1)         begin bad++; $display("[TB] FAIL byte_rd_valid: got %b want 1", v); end
      total++; if (d !== 32'hDEADBEAA) begin bad++; $display("[TB] FAIL byte_rd_data: got %h want deadbeaa", d); end
      tick();
      total++; if (bus.rd_valid !== 1'b0)     begin bad++; $display("[TB] FAIL byte_rd_pulse: got %b want 0", bus.rd_valid); end
      total++; if (bus.rd_data !== 32'hDEADBEAA) begin bad++; $display("[TB] FAIL byte_rd_hold: got %h want deadbeaa", bus.rd_data); end
   endtask

   task automatic test_random_rw();
      int ai [12];
      int aw [12];
      int ad [12];
      logic v;
      logic [DATA_SIZE-1:0] d, exp;
      for (int n = 0; n < 12; n++) begin
         ai[n] = $urandom_range(16, (1 << INDEX_SIZE) - 1);
         aw[n] = $urandom_range(0, ASSOC - 1);
         ad[n] = $urandom_range(0, WORDS - 1);
         cpu_write(ai[n], aw[n], ad[n], DATA_SIZE'($urandom), '1);
      end
      for (int n = 0; n < 40; n++) begin
         int s;
         s = $urandom_range(0, 11);
         if ($urandom_range(0, 1) == 1) begin
            cpu_write(ai[s], aw[s], ad[s], DATA_SIZE'($urandom), BE_W'($urandom));
         end else begin
            exp = model[key(ai[s], aw[s], ad[s])];
            cpu_read(ai[s], aw[s], ad[s], v, d);
            total++; if (v !== 1'b1) begin bad++; $display("[TB] FAIL rand_rd_valid: got %b want 1", v); end
            total++; if (d !== exp)  begin bad++; $display("[TB] FAIL rand_rd_data: got %h want %h", d, exp); end
         end
      end
      for (int n = 0; n < 4; n++) begin
         cpu_write(ai[n], aw[n], ad[n], DATA_SIZE'($urandom), BE_W'($urandom_range(1, (1 << BE_W) - 2)));
         exp = model[key(ai[n], aw[n], ad[n])];
         cpu_read(ai[n], aw[n], ad[n], v, d);
         total++; if (d !== exp) begin bad++; $display("[TB] FAIL raw_rd_data: got %h want %h", d, exp); end
      end
   endtask

   task automatic test_fill();
      int rl, bl, ed;
      logic v;
      logic [DATA_SIZE-1:0] d;
      for (int k = 0; k < BEATS; k++)
         for (int i = 0; i < BEAT_WORDS; i++)
            beat_q[k][i*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(k * BEAT_WORDS + i);
      run_fill(0, 7, 3, 9, rl, bl, ed);
      total++; if (rl != 0) begin bad++; $display("[TB] FAIL fill_ready_low: got %0d want 0", rl); end
      total++; if (bl != 0) begin bad++; $display("[TB] FAIL fill_busy_low: got %0d want 0", bl); end
      total++; if (ed != 0) begin bad++; $display("[TB] FAIL fill_early_done: got %0d want 0", ed); end
      total++; if (bus.done !== 1'b1)       begin bad++; $display("[TB] FAIL fill_done: got %b want 1", bus.done); end
      total++; if (bus.busy !== 1'b0)       begin bad++; $display("[TB] FAIL fill_end_busy: got %b want 0", bus.busy); end
      total++; if (bus.fill_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_end_ready: got %b want 0", bus.fill_ready); end
      tick();
      total++; if (bus.done !== 1'b0)       begin bad++; $display("[TB] FAIL fill_done_pulse: got %b want 0", bus.done); end
      cpu_read(0, 7, 37, v, d);
      total++; if (v !== 1'b1)              begin bad++; $display("[TB] FAIL fill_rd_valid: got %b want 1", v); end
      total++; if (d !== DATA_SIZE'(37))    begin bad++; $display("[TB] FAIL fill_word37: got %h want 25", d); end
   endtask

   task automatic test_evict();
      int k, cyc, dones;
      logic rdy, stalled, v;
      logic [BEAT_BITS-1:0] exp, prev;
      logic [DATA_SIZE-1:0] d, exp_w;
      bus.op = OP_EVICT;
      set_addr(0, 7, 0);
      tick();
      k = 0; cyc = 0; dones = 0; stalled = 1'b0; prev = '0;
      while (k < BEATS && cyc < 200) begin
         exp = model_beat(0, 7, k);
         total++; if (bus.evict_valid !== 1'b1) begin bad++; $display("[TB] FAIL evict_valid: got %b want 1", bus.evict_valid); end
         total++; if (bus.evict_data !== exp)   begin bad++; $display("[TB] FAIL evict_data beat %0d: got %h want %h", k, bus.evict_data, exp); end
         total++; if (bus.rd_valid !== 1'b0)    begin bad++; $display("[TB] FAIL evict_rd_valid: got %b want 0", bus.rd_valid); end
         if (stalled) begin
            total++; if (bus.evict_data !== prev) begin bad++; $display("[TB] FAIL evict_stall_stable: got %h want %h", bus.evict_data, prev); end
         end
         if (bus.done === 1'b1) dones++;
         prev = bus.evict_data;
         rdy  = (cyc % 2 == 0);
         bus.evict_ready = rdy;
         bus.op      = rdy ? OP_WRITE : OP_READ;
         set_addr(0, 7, 5);
         bus.wr_data = 32'hBAD0BAD0;
         bus.wr_be   = '1;
         stalled     = !rdy;
         if (rdy && bus.evict_valid === 1'b1) k++;
         tick();
         cyc++;
      end
      bus.op = OP_NOP;
      bus.evict_ready = 1'b0;
      total++; if (k != BEATS) begin bad++; $display("[TB] FAIL evict_timeout: got %0d beats want %0d", k, BEATS); end
      total++; if (dones != 0) begin bad++; $display("[TB] FAIL evict_early_done: got %0d want 0", dones); end
      total++; if (bus.done !== 1'b1)        begin bad++; $display("[TB] FAIL evict_done: got %b want 1", bus.done); end
      total++; if (bus.evict_valid !== 1'b0) begin bad++; $display("[TB] FAIL evict_end_valid: got %b want 0", bus.evict_valid); end
      tick();
      total++; if (bus.done !== 1'b0)        begin bad++; $display("[TB] FAIL evict_done_pulse: got %b want 0", bus.done); end
      exp_w = model[key(0, 7, 5)];
      cpu_read(0, 7, 5, v, d);
      total++; if (d !== exp_w) begin bad++; $display("[TB] FAIL evict_no_write: got %h want %h", d, exp_w); end
   endtask

   task automatic test_busy_ignore();
      int k, cyc, wd;
      logic v, fv;
      logic [DATA_SIZE-1:0] keep, d, exp_w;
      cpu_write(9, 4, 20, DATA_SIZE'($urandom), '1);
      keep = model[key(9, 4, 20)];
      for (int n = 0; n < BEATS; n++) beat_q[n] = rand_beat();
      bus.op = OP_FILL;
      set_addr(1, 2, 0);
      tick();
      k = 0; cyc = 0;
      while (k < BEATS && cyc < 100) begin
         total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_high: got %b want 1", bus.busy); end
         bus.op      = (cyc % 2 == 0) ? OP_WRITE : OP_READ;
         set_addr(9, 4, 20);
         bus.wr_data = ~keep;
         bus.wr_be   = '1;
         fv = (cyc % 3 != 1);
         bus.fill_valid = fv;
         bus.fill_data  = beat_q[k];
         if (fv && bus.fill_ready === 1'b1) begin
            model_fill_beat(1, 2, k, beat_q[k]);
            k++;
         end
         tick();
         total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL busy_rd_valid: got %b want 0", bus.rd_valid); end
         cyc++;
      end
      bus.op = OP_NOP;
      bus.fill_valid = 1'b0;
      total++; if (k != BEATS) begin bad++; $display("[TB] FAIL busy_fill_timeout: got %0d beats want %0d", k, BEATS); end
      total++; if (bus.done !== 1'b1) begin bad++; $display("[TB] FAIL busy_fill_done: got %b want 1", bus.done); end
      cpu_read(9, 4, 20, v, d);
      total++; if (d !== keep) begin bad++; $display("[TB] FAIL busy_write_ignored: got %h want %h", d, keep); end
      wd = $urandom_range(0, WORDS - 1);
      exp_w = model[key(1, 2, wd)];
      cpu_read(1, 2, wd, v, d);
      total++; if (d !== exp_w) begin bad++; $display("[TB] FAIL busy_fill_word: got %h want %h", d, exp_w); end
   endtask

   task automatic test_reset_abort();
      logic v;
      logic [DATA_SIZE-1:0] d, exp_w;
      for (int wd = 24; wd < 28; wd++) cpu_write(2, 1, wd, DATA_SIZE'($urandom), '1);
      for (int n = 0; n < BEATS; n++) beat_q[n] = rand_beat();
      bus.op = OP_FILL;
      set_addr(2, 1, 0);
      tick();
      bus.op = OP_NOP;
      for (int k = 0; k < 6; k++) begin
         bus.fill_valid = 1'b1;
         bus.fill_data  = beat_q[k];
         tick();
         model_fill_beat(2, 1, k, beat_q[k]);
      end
      bus.fill_data = beat_q[6];
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.busy !== 1'b0)        begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", bus.busy); end
      total++; if (bus.fill_ready !== 1'b0)  begin bad++; $display("[TB] FAIL abort_fill_ready: got %b want 0", bus.fill_ready); end
      total++; if (bus.evict_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_evict_valid: got %b want 0", bus.evict_valid); end
      total++; if (bus.rd_data !== '0)       begin bad++; $display("[TB] FAIL abort_rd_data: got %h want 0", bus.rd_data); end
      total++; if (bus.rd_valid !== 1'b0)    begin bad++; $display("[TB] FAIL abort_rd_valid: got %b want 0", bus.rd_valid); end
      tick();
      bus.fill_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done: got %b want 0", bus.done); end
      end
      for (int wd = 0; wd < 28; wd++) begin
         exp_w = model[key(2, 1, wd)];
         cpu_read(2, 1, wd, v, d);
         total++; if (d !== exp_w) begin bad++; $display("[TB] FAIL abort_word %0d: got %h want %h", wd, d, exp_w); end
      end
   endtask

   task automatic test_back_to_back();
      int rl, bl, ed, k, cyc, dones, wd;
      logic v;
      logic [BEAT_BITS-1:0] exp;
      logic [DATA_SIZE-1:0] d, exp_w;
      for (int n = 0; n < BEATS; n++) beat_q[n] = rand_beat();
      run_fill(3, 5, -1, -1, rl, bl, ed);
      total++; if (bus.done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_fill_done: got %b want 1", bus.done); end
      bus.op = OP_EVICT;
      set_addr(3, 5, 0);
      tick();
      bus.op = OP_NOP;
      bus.evict_ready = 1'b1;
      k = 0; cyc = 0; dones = 0;
      while (k < BEATS && cyc < 100) begin
         exp = model_beat(3, 5, k);
         total++; if (bus.evict_data !== exp) begin bad++; $display("[TB] FAIL b2b_evict_data beat %0d: got %h want %h", k, bus.evict_data, exp); end
         if (bus.done === 1'b1) dones++;
         if (bus.evict_valid === 1'b1) k++;
         tick();
         cyc++;
      end
      bus.evict_ready = 1'b0;
      total++; if (k != BEATS) begin bad++; $display("[TB] FAIL b2b_evict_timeout: got %0d beats want %0d", k, BEATS); end
      total++; if (dones != 0) begin bad++; $display("[TB] FAIL b2b_early_done: got %0d want 0", dones); end
      total++; if (bus.done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_evict_done: got %b want 1", bus.done); end
      for (int n = 0; n < BEATS; n++) beat_q[n] = rand_beat();
      run_fill(4, 6, -1, 7, rl, bl, ed);
      total++; if (rl != 0) begin bad++; $display("[TB] FAIL b2b_refill_ready_low: got %0d want 0", rl); end
      total++; if (bus.done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_refill_done: got %b want 1", bus.done); end
      wd = $urandom_range(0, WORDS - 1);
      exp_w = model[key(4, 6, wd)];
      cpu_read(4, 6, wd, v, d);
      total++; if (d !== exp_w) begin bad++; $display("[TB] FAIL b2b_refill_word: got %h want %h", d, exp_w); end
   endtask

   initial begin
      bus.op          = OP_NOP;
      bus.index       = '0;
      bus.way         = '0;
      bus.word        = '0;
      bus.wr_data     = '0;
      bus.wr_be       = '0;
      bus.fill_data   = '0;
      bus.fill_valid  = 1'b0;
      bus.evict_ready = 1'b0;
      #3;
      $display("[TB] starting data_array_burst bench");
      test_reset();
      test_byte_write();
      test_random_rw();
      test_fill();
      test_evict();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_array_burst.md
DATA_ARRAY_BURST -- requirements
Module: data_array_burst

Interface
REQ-001 Parameter ASSOC, default 8, ways per set; power of two, at least 2.
REQ-002 Parameter DATA_SIZE, default 32, word width in bits; multiple of 8.
REQ-003 Parameter BLOCK_SIZE, default 6, log2 of words per line.
REQ-004 Parameter INDEX_SIZE, default 7, log2 of sets.
REQ-005 Parameter BEAT_WORDS, default 4, words per memory beat; power of two, at most 2**BLOCK_SIZE; BEATS = 2**BLOCK_SIZE / BEAT_WORDS.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 index  in  INDEX_SIZE  set select.
REQ-009 way  in  $clog2(ASSOC)  way select, from the tag array.
REQ-010 word  in  BLOCK_SIZE  word offset within the line, CPU ops only.
REQ-011 op  in  3  operation: 000 NOP, 001 CPU write, 010 CPU read, 011 fill start, 101 evict start; all other codes are NOP.
REQ-012 wr_data  in  DATA_SIZE  CPU write word.
REQ-013 wr_be  in  DATA_SIZE/8  CPU write byte enables; bit n covers bits 8n+7:8n.
REQ-014 rd_data  out  DATA_SIZE  CPU read word, registered.
REQ-015 rd_valid  out  1  rd_data valid, one-cycle pulse.
REQ-016 fill_data  in  BEAT_WORDS*DATA_SIZE  memory beat; word i occupies bits (i+1)*DATA_SIZE-1:i*DATA_SIZE.
REQ-017 fill_valid  in  1  fill beat offered.
REQ-018 fill_ready  out  1  fill beat accepted.
REQ-019 evict_data  out  BEAT_WORDS*DATA_SIZE  evicted beat, same word packing as fill_data.
REQ-020 evict_valid  out  1  evict beat offered.
REQ-021 evict_ready  in  1  evict beat consumed.
REQ-022 busy  out  1  fill or evict in progress.
REQ-023 done  out  1  one-cycle pulse at the end of a fill or evict.

Function
REQ-024 Storage is SETS x ASSOC lines of 2**BLOCK_SIZE words each; contents are not reset and are undefined until written.
REQ-025 The FSM has three states, IDLE, FILL and EVICT; op is decoded only in IDLE and is ignored while busy=1.
REQ-026 CPU write in IDLE: on the same edge, bytes of mem[index][way][word] with wr_be=1 take wr_data; bytes with wr_be=0 are unchanged.
REQ-027 CPU read in IDLE: rd_data = mem[index][way][word] and rd_valid=1 in the following cycle; otherwise rd_valid=0 and rd_data holds its last value.
REQ-028 A read issued the cycle after a write to the same word returns the written data.
REQ-029 Fill start in IDLE: latch index and way, clear the beat counter, and enter FILL.
REQ-030 In FILL, fill_ready=1; on each cycle with fill_valid=1, words counter*BEAT_WORDS+i for i=0..BEAT_WORDS-1 of the latched line take fill_data word i, and counter increments.
REQ-031 When the beat with counter=BEATS-1 is accepted, return to IDLE and pulse done for exactly one cycle, in the next cycle.
REQ-032 Evict start in IDLE: latch index and way, clear the counter, and enter EVICT.
REQ-033 In EVICT, evict_valid=1 and evict_data = words counter*BEAT_WORDS..+BEAT_WORDS-1 of the latched line, held stable until evict_ready=1.
REQ-034 On evict_valid & evict_ready, counter increments; on the beat with counter=BEATS-1, return to IDLE and pulse done in the next cycle.
REQ-035 The counter is $clog2(BEATS) bits wide (minimum 1) and never wraps mid-operation; BEATS=1 completes in a single handshake.
REQ-036 busy=1 exactly in FILL and EVICT; fill_ready=0 and evict_valid=0 in IDLE.
REQ-037 A new fill or evict may start in the same cycle that done is high.
REQ-038 No array write occurs in EVICT, so evicted data always reflects the line contents at evict start.

Reset
REQ-039 While rst_n=0: FSM in IDLE, counter=0, rd_data=0, rd_valid=0, done=0, busy=0, fill_ready=0, evict_valid=0; array contents are retained.
REQ-040 Reset asserted during FILL or EVICT aborts the operation; a partially filled line keeps the beats already written and no done pulse is generated.

Verification
REQ-041 With default parameters, write 0xDEADBEEF with wr_be=1111 to (index 5, way 3, word 10), then write 0x000000AA with wr_be=0001, then read -> rd_valid pulse, rd_data=0xDEADBEAA.
REQ-042 Fill (index 0, way 7) with 16 beats whose word values are 0..63, with fill_valid deasserted on beats 3 and 9 -> done pulses one cycle after the 16th handshake; reading word 37 returns 37.
REQ-043 Evict that line with evict_ready toggling 1,0,1,... -> 16 beats, beat k contains words 4k..4k+3, evict_data is stable while stalled, and done pulses once.
REQ-044 Issue CPU writes and reads while busy=1 -> the array is unchanged and rd_valid stays 0.
REQ-045 Assert rst_n=0 after fill beat 5 -> outputs take reset values, busy=0, no done pulse; words 0..23 hold the filled data.
REQ-046 Start an evict in the same cycle as a fill's done pulse -> the evict begins with counter=0 and returns the newly filled data.
